// File: rtl/rf_value_responder.sv
// Responder for reflection-style GET/PUT/NEXT requests against an internal variable table.
// One request is outstanding at a time; the design side can update the table every cycle.
module rf_value_responder #(
    parameter int                  NUM_VARS = 8,
    parameter int                  DATA_W   = 32,
    parameter int                  HANDLE_W = 8,
    parameter logic [NUM_VARS-1:0] RO_MASK  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [HANDLE_W-1:0]        req_handle,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [1:0]                 rsp_status,
    output logic [HANDLE_W-1:0]        rsp_handle,
    output logic [DATA_W-1:0]          rsp_data,
    input  logic                       hw_we,
    input  logic [HANDLE_W-1:0]        hw_idx,
    input  logic [DATA_W-1:0]          hw_wdata,
    output logic [NUM_VARS*DATA_W-1:0] var_q,
    output logic [7:0]                 err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_GET  = 2'd0;
    localparam logic [1:0] OP_PUT  = 2'd1;
    localparam logic [1:0] OP_NEXT = 2'd2;

    localparam logic [1:0] STS_OK         = 2'd0;
    localparam logic [1:0] STS_BAD_HANDLE = 2'd1;
    localparam logic [1:0] STS_READ_ONLY  = 2'd2;
    localparam logic [1:0] STS_BAD_OP     = 2'd3;

    localparam logic [HANDLE_W-1:0] NUM_H  = HANDLE_W'(NUM_VARS);
    localparam logic [HANDLE_W-1:0] LAST_H = HANDLE_W'(NUM_VARS - 1);
    localparam logic [HANDLE_W-1:0] ONE_H  = HANDLE_W'(1);

    state_t              state_r;
    logic [1:0]          op_r;
    logic [HANDLE_W-1:0] handle_r;
    logic [DATA_W-1:0]   data_r;
    logic [DATA_W-1:0]   var_r [NUM_VARS];

    logic                req_ready_r;
    logic                rsp_valid_r;
    logic [1:0]          rsp_status_r;
    logic [HANDLE_W-1:0] rsp_handle_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic [7:0]          err_cnt_r;

    logic                in_range_s;
    logic                ro_s;
    logic [DATA_W-1:0]   rd_val_s;
    logic [1:0]          sts_s;
    logic [HANDLE_W-1:0] nh_s;
    logic [DATA_W-1:0]   dat_s;
    logic                put_we_s;

    // Decode the latched request into the response it will produce in EXEC.
    always_comb begin
        in_range_s = (handle_r < NUM_H);
        rd_val_s   = '0;
        ro_s       = 1'b0;
        for (int i = 0; i < NUM_VARS; i++) begin
            rd_val_s = rd_val_s | ({DATA_W{handle_r == HANDLE_W'(i)}} & var_r[i]);
            ro_s     = ro_s | ((handle_r == HANDLE_W'(i)) & RO_MASK[i]);
        end
        sts_s = STS_OK;
        nh_s  = handle_r;
        dat_s = '0;
        if (op_r == 2'd3) begin
            sts_s = STS_BAD_OP;
        end else if (!in_range_s) begin
            sts_s = STS_BAD_HANDLE;
        end else begin
            case (op_r)
                OP_GET:  dat_s = rd_val_s;
                OP_PUT:  sts_s = ro_s ? STS_READ_ONLY : STS_OK;
                OP_NEXT: begin
                    // The last entry ends the iteration rather than wrapping.
                    if (handle_r == LAST_H) begin
                        sts_s = STS_BAD_HANDLE;
                    end else begin
                        nh_s = handle_r + ONE_H;
                    end
                end
                default: sts_s = STS_BAD_OP;
            endcase
        end
        put_we_s = (state_r == ST_EXEC) && (op_r == OP_PUT) && in_range_s && !ro_s;
    end

    // Variable table: a same-entry PUT overrides the design-side write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                var_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VARS; i++) begin
                if (put_we_s && (handle_r == HANDLE_W'(i))) begin
                    var_r[i] <= data_r;
                end else if (hw_we && (hw_idx == HANDLE_W'(i))) begin
                    var_r[i] <= hw_wdata;
                end
            end
        end
    end

    // Request/execute/respond sequencer with registered handshake and response fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_r         <= 2'd0;
            handle_r     <= '0;
            data_r       <= '0;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_status_r <= STS_OK;
            rsp_handle_r <= '0;
            rsp_data_r   <= '0;
            err_cnt_r    <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        op_r        <= req_op;
                        handle_r    <= req_handle;
                        data_r      <= req_data;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_status_r <= sts_s;
                    rsp_handle_r <= nh_s;
                    rsp_data_r   <= dat_s;
                    rsp_valid_r  <= 1'b1;
                    if ((sts_s != STS_OK) && (err_cnt_r != 8'hFF)) begin
                        err_cnt_r <= err_cnt_r + 8'd1;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VARS; g++) begin : g_view
            assign var_q[g*DATA_W +: DATA_W] = var_r[g];
        end
    endgenerate

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_status = rsp_status_r;
    assign rsp_handle = rsp_handle_r;
    assign rsp_data   = rsp_data_r;
    assign err_cnt    = err_cnt_r;

endmodule
